mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares one multicycle, pipelined main memory between I-cache misses, D-cache misses and D-side stores.
//  Sits between both caches and the memory.
//  Fills one block by issuing WORDS consecutive halfword reads, then steers the returning words into the owning cache.
//  Fixed priority when idle: D store > D miss > I miss.
// PARAMETERS
//  WORDS    8   halfwords per cache block (power of 2); block = 2*WORDS bytes
//  MEM_LAT  4   memory read latency in cycles (enable cycle to valid); bench/model only
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   asynchronous reset, active-high
//  i_miss_req      in   1   I-cache miss; held high until i_fill_done
//  i_miss_addr     in   16  I miss byte address (any offset in block)
//  d_miss_req      in   1   D-cache miss; held high until d_fill_done
//  d_miss_addr     in   16  D miss byte address
//  d_wr_req        in   1   D store request; held high until d_wr_ack
//  d_wr_addr       in   16  store byte address
//  d_wr_data       in   16  store data
//  d_wr_ack        out  1   1-cycle pulse: store issued to memory
//  mem_enable      out  1   memory access this cycle
//  mem_wr          out  1   1 = write, 0 = read
//  mem_addr        out  16  memory byte address
//  mem_data_in     out  16  write data to memory
//  mem_data_out    in   16  read data from memory
//  mem_data_valid  in   1   mem_data_out valid this cycle
//  fill_data       out  16  = mem_data_out (pass-through)
//  fill_word       out  log2(WORDS)  word index of fill_data within block
//  i_fill_we       out  1   write fill_data into I-cache
//  d_fill_we       out  1   write fill_data into D-cache
//  i_fill_done     out  1   1-cycle pulse: I block complete
//  d_fill_done     out  1   1-cycle pulse: D block complete
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset state: IDLE, counters = 0, owner = I, blk_addr = 0.
//  Reset values: all outputs 0 except fill_data, which follows mem_data_out.
//  States: IDLE, WRITE, ISSUE, DRAIN, DONE. Transitions are registered; outputs decode from state and registers.
//  IDLE: d_wr_req -> WRITE; else d_miss_req -> ISSUE, owner=D; else i_miss_req -> ISSUE, owner=I.
//   On grant, latch blk_addr = addr & ~(2*WORDS-1); clear iss_cnt and rcv_cnt.
//  WRITE, 1 cycle: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1 -> IDLE.
//  ISSUE: mem_enable=1, mem_wr=0, mem_addr = blk_addr + 2*iss_cnt; iss_cnt++ each cycle.
//   Leave to DRAIN after the cycle issuing iss_cnt = WORDS-1.
//   Exactly WORDS consecutive read cycles, no gaps.
//  ISSUE/DRAIN receive: if mem_data_valid, then fill_word = rcv_cnt and owner's *_fill_we = 1; rcv_cnt++.
//   Receive can overlap ISSUE.
//   After the cycle receiving rcv_cnt = WORDS-1, go to DONE; the check applies in both ISSUE and DRAIN.
//  DONE, 1 cycle: owner's *_fill_done = 1 -> IDLE. Requester drops req in the next cycle.
//   Arbiter re-arbitrates in IDLE only.
//  Words are returned in issue order; fill_word therefore equals the block offset.
//  Counters: iss_cnt and rcv_cnt are log2(WORDS)+1 bits. Address add is mod 2^16, never crossing the block.
//  mem_data_valid in IDLE, WRITE or DONE is ignored: no we, no count change.
//  Requests arriving while busy are not granted until IDLE. Req deassert mid-fill is ignored; the fill completes.
//  Simultaneous I and D miss: D served first. I waits and is granted in the IDLE cycle after d_fill_done.
//   No I starvation guarantee beyond D priority.
//  rst mid-operation: immediate return to IDLE.
//   In-flight memory responses after reset are ignored; no done or ack is issued for the aborted op.
//  Timing (MEM_LAT=4), req high in IDLE at cycle 0: ISSUE cycles 1-8; valid and we cycles 5-12; DONE cycle 13; IDLE cycle 14.
// TESTING
//  1. I miss, i_miss_addr=0x0036, d side idle -> mem_addr 0x0030,0x0032..0x003E in cycles 1-8.
//     i_fill_we with fill_word 0..7 in cycles 5-12; i_fill_done in cycle 13; d_* all 0.
//  2. i_miss_req and d_miss_req rise in the same cycle (0x1000 / 0x2004) -> D filled first from 0x2000, d_fill_done at 13.
//     I grant at 14; I reads from 0x1000; i_fill_done at 27.
//  3. d_wr_req (0x4002, 0xBEEF) together with d_miss_req -> cycle 1 write: mem_wr=1, addr 0x4002, data 0xBEEF, d_wr_ack=1.
//     D fill then begins in cycle 3.
//  4. Spurious mem_data_valid in IDLE and in WRITE -> no fill_we, rcv_cnt stays 0, next fill still yields words 0..7.
//  5. rst asserted in cycle 6 of a D fill -> all outputs 0 at once, busy=0.
//     Late valids are ignored; a new I miss gets a full, correct 8-word fill.
//  6. Memory model with random 0-3 cycle gaps before valids (order kept) -> DONE only after 8th word; 8 we pulses total.

Source files
------------

// File: rtl/mem_fill_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_fill_arbiter_if
// Bundles every signal between the fill arbiter, the two caches and the
// shared main memory.
//   slave  modport : the arbiter side (takes requests and read data, drives
//                    memory commands and fill strobes)
//   master modport : the environment side (caches + memory)
// Signal groups:
//   I miss   : i_miss_req, i_miss_addr, i_fill_we, i_fill_done
//   D miss   : d_miss_req, d_miss_addr, d_fill_we, d_fill_done
//   D store  : d_wr_req, d_wr_addr, d_wr_data, d_wr_ack
//   memory   : mem_enable, mem_wr, mem_addr, mem_data_in,
//              mem_data_out, mem_data_valid
//   fill bus : fill_data, fill_word; busy status
// ----------------------------------------------------------------------------
interface mem_fill_arbiter_if #(
  parameter int WORDS = 8
) ();
  localparam int WW = $clog2(WORDS);

  logic          i_miss_req;
  logic [15:0]   i_miss_addr;
  logic          d_miss_req;
  logic [15:0]   d_miss_addr;
  logic          d_wr_req;
  logic [15:0]   d_wr_addr;
  logic [15:0]   d_wr_data;
  logic          d_wr_ack;
  logic          mem_enable;
  logic          mem_wr;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_data_in;
  logic [15:0]   mem_data_out;
  logic          mem_data_valid;
  logic [15:0]   fill_data;
  logic [WW-1:0] fill_word;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_fill_done;
  logic          d_fill_done;
  logic          busy;

  modport slave (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    output d_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
           fill_data, fill_word, i_fill_we, d_fill_we,
           i_fill_done, d_fill_done, busy
  );

  modport master (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
    input  d_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in,
           fill_data, fill_word, i_fill_we, d_fill_we,
           i_fill_done, d_fill_done, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// ----------------------------------------------------------------------------
// mem_fill_arbiter
// Shares one pipelined main memory between I-cache misses, D-cache misses
// and D-side stores. A miss is served by issuing WORDS back-to-back halfword
// reads of the aligned block, then steering the in-order returning words to
// the owning cache. Idle priority: D store > D miss > I miss.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous reset, active-high
//   bus  : mem_fill_arbiter_if.slave (requests, memory port, fill strobes)
// ----------------------------------------------------------------------------
module mem_fill_arbiter #(
  parameter int WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_fill_arbiter_if.slave    bus
);
  localparam int WW = $clog2(WORDS);
  localparam int CW = WW + 1;
  localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic          owner_d_q, owner_d_d;   // 1 = D-cache owns the fill
  logic [15:0]   blk_addr_q, blk_addr_d;
  logic          recv;

  // A returning word is only accepted while a fill is in flight; valids seen
  // in IDLE/WRITE/DONE (including stale ones after a reset) are dropped.
  assign recv = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && bus.mem_data_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iss_cnt_q  <= '0;
      rcv_cnt_q  <= '0;
      owner_d_q  <= 1'b0;
      blk_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      owner_d_q  <= owner_d_d;
      blk_addr_q <= blk_addr_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    owner_d_d  = owner_d_q;
    blk_addr_d = blk_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.d_wr_req) begin
          state_d = S_WRITE;
        end else if (bus.d_miss_req) begin
          state_d    = S_ISSUE;
          owner_d_d  = 1'b1;
          blk_addr_d = bus.d_miss_addr & BLK_MASK;
          iss_cnt_d  = '0;
          rcv_cnt_d  = '0;
        end else if (bus.i_miss_req) begin
          state_d    = S_ISSUE;
          owner_d_d  = 1'b0;
          blk_addr_d = bus.i_miss_addr & BLK_MASK;
          iss_cnt_d  = '0;
          rcv_cnt_d  = '0;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ISSUE: begin
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last word can arrive while still issuing (very short latency), so
    // completion overrides the ISSUE->DRAIN step.
    if (recv) begin
      rcv_cnt_d = rcv_cnt_q + 1'b1;
      if (rcv_cnt_q == LAST) state_d = S_DONE;
    end
  end

  // Output decode
  always_comb begin
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.d_wr_ack    = 1'b0;
    bus.i_fill_we   = 1'b0;
    bus.d_fill_we   = 1'b0;
    bus.fill_word   = '0;
    bus.i_fill_done = 1'b0;
    bus.d_fill_done = 1'b0;

    case (state_q)
      S_WRITE: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = bus.d_wr_addr;
        bus.mem_data_in = bus.d_wr_data;
        bus.d_wr_ack    = 1'b1;
      end
      S_ISSUE: begin
        bus.mem_enable = 1'b1;
        // Halfword stride; iss_cnt stays below WORDS here so the sum never
        // leaves the aligned block.
        bus.mem_addr   = blk_addr_q + (16'(iss_cnt_q) << 1);
      end
      S_DONE: begin
        bus.d_fill_done = owner_d_q;
        bus.i_fill_done = ~owner_d_q;
      end
      default: ;
    endcase

    if (recv) begin
      bus.fill_word = rcv_cnt_q[WW-1:0];
      bus.d_fill_we = owner_d_q;
      bus.i_fill_we = ~owner_d_q;
    end
  end

  assign bus.fill_data = bus.mem_data_out;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_fill_arbiter
// Directed bench for mem_fill_arbiter with an in-order pipelined memory
// model (fixed latency, optional random extra gaps) and a spurious-valid
// injector. Each scenario task drives its stimulus and checks inline.
// ----------------------------------------------------------------------------
module tb_mem_fill_arbiter;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_fill_arbiter_if #(.WORDS(WORDS)) bus ();
  mem_fill_arbiter #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // ---------------- memory model ----------------
  logic        mv_q = 1'b0;
  logic [15:0] md_q = 16'h0000;
  logic [15:0] q_data [64];
  int          q_due  [64];
  int          wr_ptr = 0, rd_ptr = 0, cyc = 0, last_due = 0, gap_q = 0;
  bit          gap_mode = 1'b0;
  logic        spur_valid = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic int calc_due(input int c, input int l, input int g);
    int b;
    b = c + MEM_LAT - 1;
    if (l + 1 > b) b = l + 1;
    return b + g;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    gap_q <= gap_mode ? int'($urandom_range(0, 3)) : 0;
    mv_q  <= 1'b0;
    if (rd_ptr != wr_ptr && q_due[rd_ptr % 64] == cyc) begin
      mv_q   <= 1'b1;
      md_q   <= q_data[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
    if (bus.mem_enable && !bus.mem_wr) begin
      q_data[wr_ptr % 64] <= mem_word(bus.mem_addr);
      q_due[wr_ptr % 64]  <= calc_due(cyc, last_due, gap_q);
      last_due            <= calc_due(cyc, last_due, gap_q);
      wr_ptr              <= wr_ptr + 1;
    end
  end

  assign bus.mem_data_valid = mv_q | spur_valid;
  assign bus.mem_data_out   = spur_valid ? 16'hDEAD : md_q;

  // ---------------- per-cycle sampler ----------------
  logic        s_en [64], s_wr [64], s_ack [64], s_iwe [64], s_dwe [64];
  logic        s_idn [64], s_ddn [64], s_busy [64];
  logic [15:0] s_addr [64], s_din [64], s_fd [64];
  logic [2:0]  s_fw [64];

  // Records cycles 1..n (mid-cycle) and plays the requester: a request is
  // dropped as soon as its done/ack pulse is seen.
  task automatic watch(input int n);
    for (int k = 1; k <= n && k < 64; k++) begin
      @(negedge clk);
      s_en[k]   = bus.mem_enable;  s_wr[k]  = bus.mem_wr;
      s_addr[k] = bus.mem_addr;    s_din[k] = bus.mem_data_in;
      s_ack[k]  = bus.d_wr_ack;    s_iwe[k] = bus.i_fill_we;
      s_dwe[k]  = bus.d_fill_we;   s_fw[k]  = bus.fill_word;
      s_fd[k]   = bus.fill_data;   s_idn[k] = bus.i_fill_done;
      s_ddn[k]  = bus.d_fill_done; s_busy[k] = bus.busy;
      if (bus.i_fill_done) bus.i_miss_req = 1'b0;
      if (bus.d_fill_done) bus.d_miss_req = 1'b0;
      if (bus.d_wr_ack)    bus.d_wr_req   = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.mem_enable, bus.mem_wr, bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we,
         bus.i_fill_done, bus.d_fill_done, bus.busy} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000", {bus.mem_enable, bus.mem_wr,
        bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we, bus.i_fill_done, bus.d_fill_done, bus.busy});
    end
    total++;
    if ({bus.mem_addr, bus.mem_data_in, bus.fill_word} !== 35'h0) begin
      bad++; $display("FAIL reset_data: addr=%h din=%h fw=%0d want 0", bus.mem_addr, bus.mem_data_in, bus.fill_word);
    end
    total++;
    if (bus.fill_data !== bus.mem_data_out) begin
      bad++; $display("FAIL reset_fill_data: got %h want %h", bus.fill_data, bus.mem_data_out);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", bus.busy); end
    $display("reset: done");
  endtask

  task automatic test_i_miss();
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h0036;
    watch(14);
    for (int k = 1; k <= 14; k++) begin
      logic ew;
      total++;
      if (s_en[k] !== (k <= 8) || (k <= 8 && (s_wr[k] !== 1'b0 || s_addr[k] !== 16'h0030 + 16'(2 * (k - 1))))) begin
        bad++; $display("FAIL i_issue c%0d: en=%b wr=%b addr=%h", k, s_en[k], s_wr[k], s_addr[k]);
      end
      ew = (k >= 5 && k <= 12);
      total++;
      if (s_iwe[k] !== ew || (ew && (s_fw[k] !== 3'(k - 5) || s_fd[k] !== mem_word(16'h0030 + 16'(2 * (k - 5)))))) begin
        bad++; $display("FAIL i_fill c%0d: we=%b fw=%0d fd=%h want we=%b", k, s_iwe[k], s_fw[k], s_fd[k], ew);
      end
      total++;
      if (s_idn[k] !== (k == 13) || s_dwe[k] !== 1'b0 || s_ddn[k] !== 1'b0 || s_ack[k] !== 1'b0) begin
        bad++; $display("FAIL i_done c%0d: idone=%b dwe=%b ddone=%b ack=%b", k, s_idn[k], s_dwe[k], s_ddn[k], s_ack[k]);
      end
    end
    total++;
    if (s_busy[14] !== 1'b0) begin bad++; $display("FAIL i_busy_end: got %b want 0", s_busy[14]); end
    $display("i_miss 0x0036: fill checked");
  endtask

  task automatic test_simultaneous();
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h1000;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h2004;
    watch(28);
    for (int k = 1; k <= 28; k++) begin
      logic ee, edw, eiw;
      logic [15:0] ea;
      ee = (k <= 8) || (k >= 15 && k <= 22);
      ea = (k <= 8) ? 16'h2000 + 16'(2 * (k - 1)) : 16'h1000 + 16'(2 * (k - 15));
      total++;
      if (s_en[k] !== ee || (ee && s_addr[k] !== ea)) begin
        bad++; $display("FAIL sim_issue c%0d: en=%b addr=%h want en=%b addr=%h", k, s_en[k], s_addr[k], ee, ea);
      end
      edw = (k >= 5 && k <= 12);
      eiw = (k >= 19 && k <= 26);
      total++;
      if (s_dwe[k] !== edw || s_iwe[k] !== eiw) begin
        bad++; $display("FAIL sim_we c%0d: dwe=%b iwe=%b want %b %b", k, s_dwe[k], s_iwe[k], edw, eiw);
      end
      if (edw || eiw) begin
        total++;
        if (s_fw[k] !== (edw ? 3'(k - 5) : 3'(k - 19)) ||
            s_fd[k] !== (edw ? mem_word(16'h2000 + 16'(2 * (k - 5))) : mem_word(16'h1000 + 16'(2 * (k - 19))))) begin
          bad++; $display("FAIL sim_word c%0d: fw=%0d fd=%h", k, s_fw[k], s_fd[k]);
        end
      end
      total++;
      if (s_ddn[k] !== (k == 13) || s_idn[k] !== (k == 27)) begin
        bad++; $display("FAIL sim_done c%0d: ddone=%b idone=%b", k, s_ddn[k], s_idn[k]);
      end
    end
    total++;
    if (s_busy[14] !== 1'b0 || s_busy[15] !== 1'b1 || s_busy[28] !== 1'b0) begin
      bad++; $display("FAIL sim_busy: c14=%b c15=%b c28=%b want 0 1 0", s_busy[14], s_busy[15], s_busy[28]);
    end
    $display("simultaneous I 0x1000 / D 0x2004: D then I checked");
  endtask

  task automatic test_write_priority();
    bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h4002; bus.d_wr_data = 16'hBEEF;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h600A;
    watch(16);
    total++;
    if (s_en[1] !== 1'b1 || s_wr[1] !== 1'b1 || s_addr[1] !== 16'h4002 || s_din[1] !== 16'hBEEF) begin
      bad++; $display("FAIL wr_cmd: en=%b wr=%b addr=%h din=%h want 1 1 4002 beef", s_en[1], s_wr[1], s_addr[1], s_din[1]);
    end
    for (int k = 1; k <= 16; k++) begin
      logic ee, ew;
      total++;
      if (s_ack[k] !== (k == 1)) begin bad++; $display("FAIL wr_ack c%0d: got %b", k, s_ack[k]); end
      ee = (k == 1) || (k >= 3 && k <= 10);
      total++;
      if (s_en[k] !== ee || (k >= 3 && k <= 10 && (s_wr[k] !== 1'b0 || s_addr[k] !== 16'h6000 + 16'(2 * (k - 3))))) begin
        bad++; $display("FAIL wr_fill_issue c%0d: en=%b wr=%b addr=%h", k, s_en[k], s_wr[k], s_addr[k]);
      end
      ew = (k >= 7 && k <= 14);
      total++;
      if (s_dwe[k] !== ew || (ew && s_fw[k] !== 3'(k - 7)) || s_ddn[k] !== (k == 15)) begin
        bad++; $display("FAIL wr_fill c%0d: dwe=%b fw=%0d ddone=%b", k, s_dwe[k], s_fw[k], s_ddn[k]);
      end
    end
    total++;
    if (s_busy[2] !== 1'b0) begin bad++; $display("FAIL wr_idle_gap: busy=%b want 0", s_busy[2]); end
    $display("store 0x4002=0xBEEF then D fill 0x6000 checked");
  endtask

  task automatic test_spurious_valid();
    spur_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.i_fill_we !== 1'b0 || bus.d_fill_we !== 1'b0) begin
      bad++; $display("FAIL spur_idle: iwe=%b dwe=%b want 0 0", bus.i_fill_we, bus.d_fill_we);
    end
    bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h0010; bus.d_wr_data = 16'h1234;
    @(negedge clk);
    total++;
    if (bus.d_wr_ack !== 1'b1 || bus.i_fill_we !== 1'b0 || bus.d_fill_we !== 1'b0) begin
      bad++; $display("FAIL spur_write: ack=%b iwe=%b dwe=%b want 1 0 0", bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we);
    end
    bus.d_wr_req = 1'b0; spur_valid = 1'b0;
    @(negedge clk);
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h0800;
    watch(14);
    for (int k = 1; k <= 14; k++) begin
      logic ew;
      ew = (k >= 5 && k <= 12);
      total++;
      if (s_iwe[k] !== ew || (ew && (s_fw[k] !== 3'(k - 5) || s_fd[k] !== mem_word(16'h0800 + 16'(2 * (k - 5))))) ||
          s_idn[k] !== (k == 13)) begin
        bad++; $display("FAIL spur_fill c%0d: iwe=%b fw=%0d fd=%h idone=%b", k, s_iwe[k], s_fw[k], s_fd[k], s_idn[k]);
      end
    end
    $display("spurious valids in IDLE/WRITE: following fill checked");
  endtask

  task automatic test_reset_mid_fill();
    int guard;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h7008;
    watch(5);
    @(negedge clk);
    total++;
    if (bus.d_fill_we !== 1'b1) begin bad++; $display("FAIL rst_pre: dwe=%b want 1", bus.d_fill_we); end
    rst = 1'b1;
    bus.d_miss_req = 1'b0;
    #1;
    total++;
    if ({bus.mem_enable, bus.mem_wr, bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we,
         bus.i_fill_done, bus.d_fill_done, bus.busy} !== 8'h00 ||
        {bus.mem_addr, bus.mem_data_in, bus.fill_word} !== 35'h0) begin
      bad++; $display("FAIL rst_async: ctrl=%b addr=%h fw=%0d want all 0", {bus.mem_enable, bus.mem_wr,
        bus.d_wr_ack, bus.i_fill_we, bus.d_fill_we, bus.i_fill_done, bus.d_fill_done, bus.busy}, bus.mem_addr, bus.fill_word);
    end
    @(negedge clk);
    rst = 1'b0;
    watch(8);
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (s_iwe[k] !== 1'b0 || s_dwe[k] !== 1'b0 || s_idn[k] !== 1'b0 || s_ddn[k] !== 1'b0 || s_busy[k] !== 1'b0) begin
        bad++; $display("FAIL rst_late c%0d: iwe=%b dwe=%b idn=%b ddn=%b busy=%b", k, s_iwe[k], s_dwe[k], s_idn[k], s_ddn[k], s_busy[k]);
      end
    end
    guard = 0;
    while ((rd_ptr != wr_ptr || mv_q) && guard < 50) begin @(negedge clk); guard++; end
    total++;
    if (guard >= 50) begin bad++; $display("FAIL rst_drain: memory model still busy after 50 cycles"); end
    bus.i_miss_req = 1'b1; bus.i_miss_addr = 16'h0102;
    watch(14);
    for (int k = 1; k <= 14; k++) begin
      logic ew;
      ew = (k >= 5 && k <= 12);
      total++;
      if (s_iwe[k] !== ew || (ew && (s_fw[k] !== 3'(k - 5) || s_fd[k] !== mem_word(16'h0100 + 16'(2 * (k - 5))))) ||
          s_idn[k] !== (k == 13) || s_dwe[k] !== 1'b0 || s_ddn[k] !== 1'b0) begin
        bad++; $display("FAIL rst_refill c%0d: iwe=%b fw=%0d fd=%h idone=%b", k, s_iwe[k], s_fw[k], s_fd[k], s_idn[k]);
      end
    end
    $display("reset mid D fill, then I fill 0x0100 checked");
  endtask

  task automatic test_gapped_memory();
    int nwe, ndone, last_we, done_at;
    gap_mode = 1'b1;
    bus.d_miss_req = 1'b1; bus.d_miss_addr = 16'h3010;
    watch(60);
    gap_mode = 1'b0;
    nwe = 0; ndone = 0; last_we = 0; done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k <= 8) begin
        total++;
        if (s_en[k] !== 1'b1 || s_addr[k] !== 16'h3010 + 16'(2 * (k - 1))) begin
          bad++; $display("FAIL gap_issue c%0d: en=%b addr=%h", k, s_en[k], s_addr[k]);
        end
      end
      if (s_dwe[k] === 1'b1) begin
        total++;
        if (s_fw[k] !== 3'(nwe) || s_fd[k] !== mem_word(16'h3010 + 16'(2 * nwe))) begin
          bad++; $display("FAIL gap_word %0d: fw=%0d fd=%h", nwe, s_fw[k], s_fd[k]);
        end
        nwe++; last_we = k;
      end
      if (s_ddn[k] === 1'b1) begin ndone++; done_at = k; end
    end
    total++;
    if (nwe !== 8) begin bad++; $display("FAIL gap_we_count: got %0d want 8", nwe); end
    total++;
    if (ndone !== 1 || done_at !== last_we + 1) begin
      bad++; $display("FAIL gap_done: count=%0d at c%0d want 1 at c%0d", ndone, done_at, last_we + 1);
    end
    $display("gapped memory D fill 0x3010: %0d words, done at cycle %0d", nwe, done_at);
  endtask

  initial begin
    bus.i_miss_req = 1'b0; bus.i_miss_addr = '0;
    bus.d_miss_req = 1'b0; bus.d_miss_addr = '0;
    bus.d_wr_req   = 1'b0; bus.d_wr_addr   = '0; bus.d_wr_data = '0;
    test_reset();
    test_i_miss();
    test_simultaneous();
    test_write_priority();
    test_spurious_valid();
    test_reset_mid_fill();
    test_gapped_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
